// File: rtl/axi_resp_pkg.sv
// Shared response codes, FSM state types and address decode for the external memory responder.
package axi_resp_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic       {W_IDLE, W_RESP}         wr_state_t;
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} rd_state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } wr_req_t;

  // Unsigned offset compare: addresses below base wrap to huge offsets and miss.
  function automatic logic addr_hit(input logic [31:0] addr, input logic [31:0] base,
                                    input logic [32:0] span);
    logic [31:0] off;
    off = addr - base;
    return {1'b0, off} < span;
  endfunction

endpackage

// File: rtl/axi_resp_ram.sv
// Word-wide RAM with per-byte write enables and a registered read port.
module axi_resp_ram #(
  parameter int WORDS = 4096,
  parameter int AW    = $clog2(WORDS)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [3:0]    wstrb,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] ram [0:WORDS-1];

  always_ff @(posedge clk_i) begin
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb[b]) ram[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
  end

  // Contents are never reset; only the read register is.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)  rdata <= '0;
    else if (re) rdata <= ram[raddr];
  end

endmodule

// File: rtl/axi_ext_mem_responder.sv
// Single-beat AXI memory responder: independent write/read FSMs over a byte-enable RAM,
// with handshake counters for telemetry.
module axi_ext_mem_responder
  import axi_resp_pkg::*;
#(
  parameter logic [31:0] MEM_BASE     = 32'h8000_0000,
  parameter int          MEM_WORDS    = 4096,
  parameter int          READ_LATENCY = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        axi_awvalid_i,
  input  logic [31:0] axi_awaddr_i,
  input  logic        axi_wvalid_i,
  input  logic [31:0] axi_wdata_i,
  input  logic [3:0]  axi_wstrb_i,
  input  logic        axi_bready_i,
  input  logic        axi_arvalid_i,
  input  logic [31:0] axi_araddr_i,
  input  logic        axi_rready_i,
  output logic        axi_awready_o,
  output logic        axi_wready_o,
  output logic        axi_bvalid_o,
  output logic [1:0]  axi_bresp_o,
  output logic        axi_arready_o,
  output logic        axi_rvalid_o,
  output logic [31:0] axi_rdata_o,
  output logic [1:0]  axi_rresp_o,
  output logic [31:0] wr_count_o,
  output logic [31:0] rd_count_o,
  output logic [31:0] err_count_o
);

  localparam int          AW   = $clog2(MEM_WORDS);
  localparam logic [32:0] SPAN = 33'(MEM_WORDS) << 2;
  localparam logic [3:0]  LAT  = 4'(READ_LATENCY);

  wr_state_t     wr_state, wr_next;
  rd_state_t     rd_state, rd_next;
  logic          aw_held, w_held;
  wr_req_t       wr_q, wr_cur;
  logic [1:0]    bresp_q, rresp_q;
  logic [3:0]    lat_cnt;
  logic [31:0]   araddr_q, ram_rdata;
  logic [AW-1:0] wr_idx, rd_idx;
  logic          aw_fire, w_fire, commit, b_fire, ar_fire, r_fire, rd_load;
  logic          wr_hit, rd_hit, ram_we, b_err, r_err;

  assign axi_awready_o = (wr_state == W_IDLE) && !aw_held;
  assign axi_wready_o  = (wr_state == W_IDLE) && !w_held;
  assign axi_bvalid_o  = (wr_state == W_RESP);
  assign axi_bresp_o   = bresp_q;
  assign axi_arready_o = (rd_state == R_IDLE);
  assign axi_rvalid_o  = (rd_state == R_RESP);
  assign axi_rresp_o   = rresp_q;
  assign axi_rdata_o   = (rresp_q == RESP_OKAY) ? ram_rdata : '0;

  assign aw_fire = axi_awvalid_i && axi_awready_o;
  assign w_fire  = axi_wvalid_i && axi_wready_o;
  assign b_fire  = axi_bvalid_o && axi_bready_i;
  assign ar_fire = axi_arvalid_i && axi_arready_o;
  assign r_fire  = axi_rvalid_o && axi_rready_i;
  assign commit  = (wr_state == W_IDLE) && (aw_held || aw_fire) && (w_held || w_fire);
  assign rd_load = (rd_state == R_WAIT) && (lat_cnt == '0);

  // A half arriving on the commit edge bypasses its holding register.
  always_comb begin
    wr_cur = wr_q;
    if (!aw_held) wr_cur.addr = axi_awaddr_i;
    if (!w_held) begin
      wr_cur.data = axi_wdata_i;
      wr_cur.strb = axi_wstrb_i;
    end
  end

  assign wr_hit = addr_hit(wr_cur.addr, MEM_BASE, SPAN);
  assign rd_hit = addr_hit(araddr_q, MEM_BASE, SPAN);
  assign wr_idx = AW'((wr_cur.addr - MEM_BASE) >> 2);
  assign rd_idx = AW'((araddr_q - MEM_BASE) >> 2);
  // Readies are high during reset, so the RAM write is also gated by reset.
  assign ram_we = commit && wr_hit && rst_i;

  axi_resp_ram #(.WORDS(MEM_WORDS), .AW(AW)) u_ram (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .we    (ram_we),
    .waddr (wr_idx),
    .wdata (wr_cur.data),
    .wstrb (wr_cur.strb),
    .re    (rd_load && rd_hit),
    .raddr (rd_idx),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_state <= W_IDLE;
      rd_state <= R_IDLE;
    end else begin
      wr_state <= wr_next;
      rd_state <= rd_next;
    end
  end

  always_comb begin
    wr_next = wr_state;
    case (wr_state)
      W_IDLE:  if (commit) wr_next = W_RESP;
      W_RESP:  if (b_fire) wr_next = W_IDLE;
      default: wr_next = W_IDLE;
    endcase
  end

  // Latency 0 still spends one R_WAIT cycle so rvalid always follows AR by 1+READ_LATENCY edges.
  always_comb begin
    rd_next = rd_state;
    case (rd_state)
      R_IDLE:  if (ar_fire) rd_next = R_WAIT;
      R_WAIT:  if (lat_cnt == '0) rd_next = R_RESP;
      R_RESP:  if (r_fire) rd_next = R_IDLE;
      default: rd_next = R_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      aw_held  <= 1'b0;
      w_held   <= 1'b0;
      wr_q     <= '0;
      bresp_q  <= RESP_OKAY;
      araddr_q <= '0;
      lat_cnt  <= '0;
      rresp_q  <= RESP_OKAY;
    end else begin
      if (aw_fire) begin
        aw_held     <= 1'b1;
        wr_q.addr   <= axi_awaddr_i;
      end
      if (w_fire) begin
        w_held      <= 1'b1;
        wr_q.data   <= axi_wdata_i;
        wr_q.strb   <= axi_wstrb_i;
      end
      if (commit) bresp_q <= wr_hit ? RESP_OKAY : RESP_SLVERR;
      if (b_fire) begin
        aw_held <= 1'b0;
        w_held  <= 1'b0;
      end
      if (ar_fire) begin
        araddr_q <= axi_araddr_i;
        lat_cnt  <= LAT;
      end else if (rd_state == R_WAIT && lat_cnt != '0) begin
        lat_cnt  <= lat_cnt - 4'd1;
      end
      if (rd_load) rresp_q <= rd_hit ? RESP_OKAY : RESP_SLVERR;
    end
  end

  assign b_err = b_fire && (bresp_q != RESP_OKAY);
  assign r_err = r_fire && (rresp_q != RESP_OKAY);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_count_o  <= '0;
      rd_count_o  <= '0;
      err_count_o <= '0;
    end else begin
      if (b_fire && !b_err) wr_count_o <= wr_count_o + 32'd1;
      if (r_fire && !r_err) rd_count_o <= rd_count_o + 32'd1;
      err_count_o <= err_count_o + 32'(b_err) + 32'(r_err);
    end
  end

endmodule

// File: tb/tb_axi_ext_mem_responder.sv
// Directed bench for axi_ext_mem_responder with a transaction-level memory model checked every cycle.
module tb_axi_ext_mem_responder;

  localparam logic [31:0] BASE  = 32'h8000_0000;
  localparam int          WORDS = 4096;
  localparam int          LAT   = 2;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        axi_awvalid_i = 1'b0, axi_wvalid_i = 1'b0, axi_arvalid_i = 1'b0;
  logic        axi_bready_i = 1'b1, axi_rready_i = 1'b1;
  logic [31:0] axi_awaddr_i = '0, axi_wdata_i = '0, axi_araddr_i = '0;
  logic [3:0]  axi_wstrb_i = '0;
  logic        axi_awready_o, axi_wready_o, axi_bvalid_o, axi_arready_o, axi_rvalid_o;
  logic [1:0]  axi_bresp_o, axi_rresp_o;
  logic [31:0] axi_rdata_o, wr_count_o, rd_count_o, err_count_o;

  int checks = 0;
  int errors = 0;

  axi_ext_mem_responder #(.MEM_BASE(BASE), .MEM_WORDS(WORDS), .READ_LATENCY(LAT)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .axi_awvalid_i(axi_awvalid_i), .axi_awaddr_i(axi_awaddr_i),
    .axi_wvalid_i(axi_wvalid_i), .axi_wdata_i(axi_wdata_i), .axi_wstrb_i(axi_wstrb_i),
    .axi_bready_i(axi_bready_i),
    .axi_arvalid_i(axi_arvalid_i), .axi_araddr_i(axi_araddr_i),
    .axi_rready_i(axi_rready_i),
    .axi_awready_o(axi_awready_o), .axi_wready_o(axi_wready_o),
    .axi_bvalid_o(axi_bvalid_o), .axi_bresp_o(axi_bresp_o),
    .axi_arready_o(axi_arready_o),
    .axi_rvalid_o(axi_rvalid_o), .axi_rdata_o(axi_rdata_o), .axi_rresp_o(axi_rresp_o),
    .wr_count_o(wr_count_o), .rd_count_o(rd_count_o), .err_count_o(err_count_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- memory model ----------------
  logic [31:0] mem_m [int];
  bit          aw_have, w_have, b_busy, r_busy, m_rknown;
  int          r_age;
  logic [31:0] m_waddr, m_wdata, m_araddr, m_rdata;
  logic [3:0]  m_wstrb;
  logic [1:0]  m_bresp, m_rresp;
  int unsigned m_wr, m_rd, m_err;

  function automatic bit in_rng(input logic [31:0] a);
    return ({32'b0, a} >= {32'b0, BASE}) && ({32'b0, a} < {32'b0, BASE} + 64'(4 * WORDS));
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'((a - BASE) >> 2);
  endfunction

  always @(negedge clk_i) begin
    bit exp_awr, exp_wr, exp_rv;
    if (!rst_i) begin
      aw_have = 0; w_have = 0; b_busy = 0; r_busy = 0; r_age = 0;
      m_wr = 0; m_rd = 0; m_err = 0;
      chk("rst_awready", axi_awready_o, 1);
      chk("rst_wready", axi_wready_o, 1);
      chk("rst_arready", axi_arready_o, 1);
      chk("rst_bvalid", axi_bvalid_o, 0);
      chk("rst_rvalid", axi_rvalid_o, 0);
      chk("rst_bresp", axi_bresp_o, 0);
      chk("rst_rresp", axi_rresp_o, 0);
      chk("rst_rdata", axi_rdata_o, 0);
      chk("rst_counts", wr_count_o | rd_count_o | err_count_o, 0);
    end else begin
      exp_awr = !b_busy && !aw_have;
      exp_wr  = !b_busy && !w_have;
      exp_rv  = r_busy && (r_age >= LAT + 1);
      chk("awready", axi_awready_o, exp_awr);
      chk("wready", axi_wready_o, exp_wr);
      chk("bvalid", axi_bvalid_o, b_busy);
      chk("arready", axi_arready_o, !r_busy);
      chk("rvalid", axi_rvalid_o, exp_rv);
      if (b_busy) chk("bresp", axi_bresp_o, m_bresp);
      if (exp_rv) begin
        chk("rresp", axi_rresp_o, m_rresp);
        if (m_rknown) chk("rdata", axi_rdata_o, m_rdata);
      end
      chk("wr_count", wr_count_o, m_wr);
      chk("rd_count", rd_count_o, m_rd);
      chk("err_count", err_count_o, m_err);
      // Predict the coming edge; read sampling happens before a write committing on that edge.
      if (r_busy) begin
        if (exp_rv) begin
          if (axi_rready_i) begin
            r_busy = 0;
            if (m_rresp == 2'b00) m_rd++; else m_err++;
          end
        end else begin
          if (r_age == LAT) begin
            if (in_rng(m_araddr)) begin
              m_rresp  = 2'b00;
              m_rknown = mem_m.exists(widx(m_araddr));
              m_rdata  = m_rknown ? mem_m[widx(m_araddr)] : 32'h0;
            end else begin
              m_rresp = 2'b10; m_rdata = 32'h0; m_rknown = 1;
            end
          end
          r_age++;
        end
      end else if (axi_arvalid_i) begin
        r_busy = 1; r_age = 0; m_araddr = axi_araddr_i;
      end
      if (b_busy) begin
        if (axi_bready_i) begin
          b_busy = 0; aw_have = 0; w_have = 0;
          if (m_bresp == 2'b00) m_wr++; else m_err++;
        end
      end else begin
        if (axi_awvalid_i && exp_awr) begin aw_have = 1; m_waddr = axi_awaddr_i; end
        if (axi_wvalid_i && exp_wr) begin w_have = 1; m_wdata = axi_wdata_i; m_wstrb = axi_wstrb_i; end
        if (aw_have && w_have) begin
          b_busy  = 1;
          m_bresp = in_rng(m_waddr) ? 2'b00 : 2'b10;
          if (in_rng(m_waddr)) begin
            if (mem_m.exists(widx(m_waddr)) || m_wstrb == 4'hF) begin
              logic [31:0] w;
              w = mem_m.exists(widx(m_waddr)) ? mem_m[widx(m_waddr)] : 32'h0;
              for (int b = 0; b < 4; b++) if (m_wstrb[b]) w[b*8 +: 8] = m_wdata[b*8 +: 8];
              mem_m[widx(m_waddr)] = w;
            end else begin
              mem_m.delete(widx(m_waddr));
            end
          end
        end
      end
    end
  end

  // ---------------- drivers (called at posedge+1) ----------------
  task automatic send(input bit aw, input bit w, input bit ar,
                      input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    bit aw_ok, w_ok, ar_ok;
    axi_awvalid_i = aw; axi_wvalid_i = w; axi_arvalid_i = ar;
    axi_awaddr_i = a; axi_araddr_i = a; axi_wdata_i = d; axi_wstrb_i = s;
    for (int i = 0; i < 40 && (axi_awvalid_i || axi_wvalid_i || axi_arvalid_i); i++) begin
      @(negedge clk_i);
      aw_ok = axi_awvalid_i && axi_awready_o;
      w_ok  = axi_wvalid_i && axi_wready_o;
      ar_ok = axi_arvalid_i && axi_arready_o;
      @(posedge clk_i); #1;
      if (aw_ok) axi_awvalid_i = 0;
      if (w_ok)  axi_wvalid_i = 0;
      if (ar_ok) axi_arvalid_i = 0;
    end
    chk("handshake_timeout", {axi_awvalid_i, axi_wvalid_i, axi_arvalid_i}, 0);
    axi_awvalid_i = 0; axi_wvalid_i = 0; axi_arvalid_i = 0;
  endtask

  task automatic wait_b(input logic [1:0] exp, input int exp_lat);
    int  k;
    bit  seen = 0;
    for (k = 1; k <= 40; k++) begin
      @(negedge clk_i);
      if (axi_bvalid_o) begin seen = 1; break; end
    end
    chk("b_seen", seen, 1);
    if (seen) begin
      chk("bresp_lit", axi_bresp_o, exp);
      if (exp_lat > 0) chk("b_latency", k, exp_lat);
    end
    @(posedge clk_i); #1;
  endtask

  task automatic wait_r(input logic [31:0] exp_d, input logic [1:0] exp_r, input int exp_lat);
    int  k;
    bit  seen = 0;
    for (k = 1; k <= 40; k++) begin
      @(negedge clk_i);
      if (axi_rvalid_o) begin seen = 1; break; end
    end
    chk("r_seen", seen, 1);
    if (seen) begin
      chk("rdata_lit", axi_rdata_o, exp_d);
      chk("rresp_lit", axi_rresp_o, exp_r);
      if (exp_lat > 0) chk("r_latency", k, exp_lat);
    end
    @(posedge clk_i); #1;
  endtask

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    repeat (3) @(negedge clk_i);
    chk("reset_arready_lit", axi_arready_o, 1);
    chk("reset_wr_count_lit", wr_count_o, 0);
    @(posedge clk_i); #1 rst_i = 1;
    @(posedge clk_i); #1;

    // write then read, same-cycle AW+W
    send(1, 1, 0, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF);
    wait_b(2'b00, 1);
    send(0, 0, 1, 32'h8000_0010, 0, 0);
    wait_r(32'hDEAD_BEEF, 2'b00, LAT + 2);
    chk("wr_count_lit1", wr_count_o, 1);
    chk("rd_count_lit1", rd_count_o, 1);

    // W leads AW by 3 cycles
    send(0, 1, 0, 0, 32'h0000_AA00, 4'b0010);
    repeat (3) begin
      @(negedge clk_i);
      chk("wlead_wready_lit", axi_wready_o, 0);
      chk("wlead_awready_lit", axi_awready_o, 1);
      @(posedge clk_i); #1;
    end
    send(1, 0, 0, 32'h8000_0010, 0, 0);
    wait_b(2'b00, 1);
    send(0, 0, 1, 32'h8000_0010, 0, 0);
    wait_r(32'hDEAD_AAEF, 2'b00, LAT + 2);

    // B backpressure with a second write waiting
    axi_bready_i = 0;
    send(1, 1, 0, 32'h8000_0020, 32'h1234_5678, 4'hF);
    axi_awvalid_i = 1; axi_wvalid_i = 1; axi_awaddr_i = 32'h8000_0024;
    axi_wdata_i = 32'hCAFE_F00D; axi_wstrb_i = 4'hF;
    repeat (5) begin
      @(negedge clk_i);
      chk("bp_bvalid_lit", axi_bvalid_o, 1);
      chk("bp_awready_lit", axi_awready_o, 0);
      chk("bp_wready_lit", axi_wready_o, 0);
    end
    @(posedge clk_i); #1 axi_bready_i = 1;
    send(1, 1, 0, 32'h8000_0024, 32'hCAFE_F00D, 4'hF);
    wait_b(2'b00, 1);
    send(0, 0, 1, 32'h8000_0020, 0, 0);
    wait_r(32'h1234_5678, 2'b00, LAT + 2);
    send(0, 0, 1, 32'h8000_0024, 0, 0);
    wait_r(32'hCAFE_F00D, 2'b00, LAT + 2);

    // out of range, one word past the top (aliases word 0 if decode were truncated)
    send(1, 1, 0, 32'h8000_0000, 32'h1122_3344, 4'hF);
    wait_b(2'b00, 1);
    send(0, 0, 1, 32'h8000_4000, 0, 0);
    wait_r(32'h0, 2'b10, LAT + 2);
    send(1, 1, 0, 32'h8000_4000, 32'hFFFF_FFFF, 4'hF);
    wait_b(2'b10, 1);
    send(0, 0, 1, 32'h8000_0000, 0, 0);
    wait_r(32'h1122_3344, 2'b00, LAT + 2);
    chk("oor_err_count_lit", err_count_o, 2);
    chk("oor_wr_count_lit", wr_count_o, 5);
    chk("oor_rd_count_lit", rd_count_o, 5);
    send(0, 0, 1, 32'h7FFF_FFFC, 0, 0);
    wait_r(32'h0, 2'b10, LAT + 2);
    chk("below_err_count_lit", err_count_o, 3);

    // reset while the read is waiting
    send(0, 0, 1, 32'h8000_0010, 0, 0);
    #2 rst_i = 0;
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1;
    repeat (6) begin
      @(negedge clk_i);
      chk("rstw_rvalid_lit", axi_rvalid_o, 0);
      chk("rstw_arready_lit", axi_arready_o, 1);
    end
    chk("rstw_counts_lit", wr_count_o | rd_count_o | err_count_o, 0);
    @(posedge clk_i); #1;
    send(0, 0, 1, 32'h8000_0010, 0, 0);
    wait_r(32'hDEAD_AAEF, 2'b00, LAT + 2);
    chk("rstw_rd_count_lit", rd_count_o, 1);

    // write committing on the read's data edge is not seen by that read
    send(0, 0, 1, 32'h8000_0010, 0, 0);
    @(posedge clk_i); @(posedge clk_i); #1;
    send(1, 1, 0, 32'h8000_0010, 32'h0BAD_0BAD, 4'hF);
    wait_r(32'hDEAD_AAEF, 2'b00, 0);
    send(0, 0, 1, 32'h8000_0010, 0, 0);
    wait_r(32'h0BAD_0BAD, 2'b00, LAT + 2);

    repeat (3) @(posedge clk_i);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
